alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_WIDTH, default 3, log2 of entry count (8 entries).
REQ-002 Parameter ROB_WIDTH, default from shared define `ROB_WIDTH, tag width.
REQ-003 clk_in  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global ready; low = pause.
REQ-006 clear  input  1  misprediction flush.
REQ-007 disp_valid  input  1  dispatch request this cycle.
REQ-008 disp_op  input  5  ALU opcode (ADD..AND, BEQ..BGEU encodings).
REQ-009 disp_vj, disp_vk  input  32 each  operand values, meaningful when the matching q-valid is low.
REQ-010 disp_qj_valid, disp_qk_valid  input  1 each  operand still pending.
REQ-011 disp_qj, disp_qk  input  ROB_WIDTH each  producing ROB tag.
REQ-012 disp_rob  input  ROB_WIDTH  destination ROB tag.
REQ-013 disp_true_jaddr, disp_false_jaddr  input  32 each  branch targets.
REQ-014 cdb_valid, cdb_rob, cdb_value  input  1/ROB_WIDTH/32  result broadcast.
REQ-015 full  output  1  no free entry.
REQ-016 calc_enable  output  1  issue strobe to ALU.
REQ-017 lhs, rhs  output  32 each; op  output  5; rob_dep  output  ROB_WIDTH; true_jaddr, false_jaddr  output  32 each: issued payload.

Function
REQ-018 Each entry SHALL hold busy, op, vj, vk, qj_valid, qj, qk_valid, qk, rob, true/false jaddr.
REQ-019 full SHALL be combinational: high when all entries busy; disp_valid while full SHALL be ignored.
REQ-020 Dispatch SHALL write the lowest-index free entry at the edge and set busy.
REQ-021 Dispatch bypass: if cdb_valid and cdb_rob equals disp_qj (disp_qj_valid high) in the same cycle, entry SHALL store vj=cdb_value, qj_valid=0; same for k.
REQ-022 Wakeup: every busy entry with qj_valid and qj==cdb_rob under cdb_valid SHALL take vj=cdb_value, qj_valid=0; same for k, both operands in one cycle allowed.
REQ-023 Entry ready = busy & !qj_valid & !qk_valid, from registered state only; woken at edge t, issuable in cycle t+1.
REQ-024 Each cycle the lowest-index ready entry SHALL issue: at the edge, calc_enable<=1, lhs<=vj, rhs<=vk, op, rob_dep, jaddrs copied, busy<=0.
REQ-025 No ready entry: calc_enable<=0; payload outputs hold.
REQ-026 Issue-to-calc_enable latency SHALL be exactly one edge; at most one issue per cycle.
REQ-027 An entry freed by issue at edge t SHALL be reusable by dispatch only from cycle t+1 (full uses pre-edge state).
REQ-028 rdy_in low: all registers including outputs SHALL hold; dispatch and CDB ignored.
REQ-029 clear high with rdy_in high: all busy<=0, calc_enable<=0; clear dominates dispatch, wakeup and issue.

Reset
REQ-030 rst_in high SHALL clear all busy and q-valid bits, calc_enable, lhs, rhs, rob_dep, jaddrs to 0, op to NOP (5'b11111), regardless of rdy_in.
REQ-031 Entry payload fields need no reset value.

Structure
REQ-032 ROB_WIDTH, RS_WIDTH default and the opcode encodings (incl. NOP) SHALL live in the shared defines header used by the ALU.
REQ-033 One sub-module rs_pick SHALL be a parameterised lowest-set-bit priority encoder (found flag + index), instantiated twice: free-slot and ready-slot selection.

Verification
REQ-034 Dispatch ADD vj=5 vk=7 both ready, rob=3 at cycle 0 -> cycle 2 calc_enable=1, lhs=5, rhs=7, op=ADD, rob_dep=3, single cycle.
REQ-035 Dispatch SUB qj=4 pending; cdb rob=4 value=100 at cycle 3 -> calc_enable at cycle 5 with lhs=100; same test with cdb in dispatch cycle -> issue as if ready at dispatch.
REQ-036 Dispatch 8 ready entries back-to-back with issue blocked by pending operands, then fill -> full=1, 9th dispatch dropped, entries issue lowest index first.
REQ-037 rdy_in low for 3 cycles while calc_enable=1 -> outputs unchanged throughout, no entry lost or issued twice.
REQ-038 clear with 5 busy entries and calc_enable=1 -> next cycle calc_enable=0, full=0, no further issue; rst_in mid-operation -> REQ-030 values next edge.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encodings and payload types for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned ROB_WIDTH_DEF = 4;
  localparam int unsigned RS_WIDTH_DEF  = 3;
  localparam int unsigned OP_W          = 5;
  localparam int unsigned XLEN          = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd7;
  localparam logic [OP_W-1:0] OP_OR   = 5'd8;
  localparam logic [OP_W-1:0] OP_AND  = 5'd9;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd10;
  localparam logic [OP_W-1:0] OP_BNE  = 5'd11;
  localparam logic [OP_W-1:0] OP_BLT  = 5'd12;
  localparam logic [OP_W-1:0] OP_BGE  = 5'd13;
  localparam logic [OP_W-1:0] OP_BLTU = 5'd14;
  localparam logic [OP_W-1:0] OP_BGEU = 5'd15;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11111;

  // Fields of an entry that never change after dispatch.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] true_jaddr;
    logic [XLEN-1:0] false_jaddr;
  } entry_pl_t;

  // Operand/target bundle presented to the ALU on issue.
  typedef struct packed {
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] true_jaddr;
    logic [XLEN-1:0] false_jaddr;
  } issue_pl_t;

  localparam issue_pl_t ISSUE_RST = '{
    lhs: '0, rhs: '0, op: OP_NOP, true_jaddr: '0, false_jaddr: '0
  };

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-set-bit priority encoder: reports whether any request is set and its index.
module rs_pick #(
  parameter int unsigned W = 8,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops the CDB for wakeup and issues the lowest-index ready entry each cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_WIDTH  = RS_WIDTH_DEF,
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 disp_valid,
  input  logic [OP_W-1:0]      disp_op,
  input  logic [XLEN-1:0]      disp_vj,
  input  logic [XLEN-1:0]      disp_vk,
  input  logic                 disp_qj_valid,
  input  logic                 disp_qk_valid,
  input  logic [ROB_WIDTH-1:0] disp_qj,
  input  logic [ROB_WIDTH-1:0] disp_qk,
  input  logic [ROB_WIDTH-1:0] disp_rob,
  input  logic [XLEN-1:0]      disp_true_jaddr,
  input  logic [XLEN-1:0]      disp_false_jaddr,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob,
  input  logic [XLEN-1:0]      cdb_value,
  output logic                 full,
  output logic                 calc_enable,
  output logic [XLEN-1:0]      lhs,
  output logic [XLEN-1:0]      rhs,
  output logic [OP_W-1:0]      op,
  output logic [ROB_WIDTH-1:0] rob_dep,
  output logic [XLEN-1:0]      true_jaddr,
  output logic [XLEN-1:0]      false_jaddr
);

  localparam int unsigned RS_SIZE = 2 ** RS_WIDTH;

  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [RS_SIZE-1:0]   qj_valid_q, qj_valid_d;
  logic [RS_SIZE-1:0]   qk_valid_q, qk_valid_d;
  logic [ROB_WIDTH-1:0] qj_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_d [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_d [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_d [RS_SIZE];
  logic [XLEN-1:0]      vj_q [RS_SIZE];
  logic [XLEN-1:0]      vj_d [RS_SIZE];
  logic [XLEN-1:0]      vk_q [RS_SIZE];
  logic [XLEN-1:0]      vk_d [RS_SIZE];
  entry_pl_t            pl_q [RS_SIZE];
  entry_pl_t            pl_d [RS_SIZE];

  logic                 calc_en_q, calc_en_d;
  issue_pl_t            iss_q, iss_d;
  logic [ROB_WIDTH-1:0] rob_dep_q, rob_dep_d;

  logic [RS_SIZE-1:0]   free_vec, ready_vec;
  logic                 free_found, ready_found;
  logic [RS_WIDTH-1:0]  free_idx, ready_idx;
  logic                 byp_j, byp_k;

  assign free_vec  = ~busy_q;
  assign ready_vec = busy_q & ~qj_valid_q & ~qk_valid_q;
  assign full      = &busy_q;

  rs_pick #(.W(RS_SIZE)) u_free_pick (
    .req_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_pick #(.W(RS_SIZE)) u_ready_pick (
    .req_i   (ready_vec),
    .found_o (ready_found),
    .idx_o   (ready_idx)
  );

  // A tag broadcast in the dispatch cycle is captured directly into the new entry.
  assign byp_j = disp_qj_valid && cdb_valid && (cdb_rob == disp_qj);
  assign byp_k = disp_qk_valid && cdb_valid && (cdb_rob == disp_qk);

  always_comb begin
    busy_d     = busy_q;
    qj_valid_d = qj_valid_q;
    qk_valid_d = qk_valid_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    rob_d      = rob_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    pl_d       = pl_q;
    calc_en_d  = calc_en_q;
    iss_d      = iss_q;
    rob_dep_d  = rob_dep_q;

    if (rdy_in) begin
      if (clear) begin
        busy_d    = '0;
        calc_en_d = 1'b0;
      end else begin
        calc_en_d = ready_found;
        if (ready_found) begin
          iss_d.lhs         = vj_q[ready_idx];
          iss_d.rhs         = vk_q[ready_idx];
          iss_d.op          = pl_q[ready_idx].op;
          iss_d.true_jaddr  = pl_q[ready_idx].true_jaddr;
          iss_d.false_jaddr = pl_q[ready_idx].false_jaddr;
          rob_dep_d         = rob_q[ready_idx];
          busy_d[ready_idx] = 1'b0;
        end

        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (cdb_valid && busy_q[i] && qj_valid_q[i] && (qj_q[i] == cdb_rob)) begin
            vj_d[i]       = cdb_value;
            qj_valid_d[i] = 1'b0;
          end
          if (cdb_valid && busy_q[i] && qk_valid_q[i] && (qk_q[i] == cdb_rob)) begin
            vk_d[i]       = cdb_value;
            qk_valid_d[i] = 1'b0;
          end
        end

        // Free slot is never a ready or waking slot, so these writes cannot collide.
        if (disp_valid && free_found) begin
          busy_d[free_idx]     = 1'b1;
          qj_valid_d[free_idx] = disp_qj_valid && !byp_j;
          qk_valid_d[free_idx] = disp_qk_valid && !byp_k;
          qj_d[free_idx]       = disp_qj;
          qk_d[free_idx]       = disp_qk;
          vj_d[free_idx]       = byp_j ? cdb_value : disp_vj;
          vk_d[free_idx]       = byp_k ? cdb_value : disp_vk;
          rob_d[free_idx]      = disp_rob;
          pl_d[free_idx]       = '{op: disp_op, true_jaddr: disp_true_jaddr,
                                   false_jaddr: disp_false_jaddr};
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      qj_valid_q <= '0;
      qk_valid_q <= '0;
      calc_en_q  <= 1'b0;
      iss_q      <= ISSUE_RST;
      rob_dep_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      qj_valid_q <= qj_valid_d;
      qk_valid_q <= qk_valid_d;
      calc_en_q  <= calc_en_d;
      iss_q      <= iss_d;
      rob_dep_q  <= rob_dep_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    rob_q <= rob_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    pl_q  <= pl_d;
  end

  assign calc_enable = calc_en_q;
  assign lhs         = iss_q.lhs;
  assign rhs         = iss_q.rhs;
  assign op          = iss_q.op;
  assign true_jaddr  = iss_q.true_jaddr;
  assign false_jaddr = iss_q.false_jaddr;
  assign rob_dep     = rob_dep_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed table, corner sequences and a randomized
// run compared every cycle against an entry-list reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int unsigned RW = ROB_WIDTH_DEF;
  localparam int NENT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, clear, disp_valid, disp_qj_valid, disp_qk_valid, cdb_valid;
  logic [4:0]    disp_op;
  logic [31:0]   disp_vj, disp_vk, disp_tj, disp_fj, cdb_value;
  logic [RW-1:0] disp_qj, disp_qk, disp_rob, cdb_rob;
  logic          full, calc_enable;
  logic [31:0]   lhs, rhs, true_jaddr, false_jaddr;
  logic [4:0]    op;
  logic [RW-1:0] rob_dep;

  alu_rs dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rob(disp_rob),
    .disp_true_jaddr(disp_tj), .disp_false_jaddr(disp_fj),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .full(full), .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op),
    .rob_dep(rob_dep), .true_jaddr(true_jaddr), .false_jaddr(false_jaddr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a list of waiting instructions plus the last issued bundle.
  typedef struct {
    bit            busy;
    bit            pj, pk;
    logic [4:0]    op;
    logic [31:0]   vj, vk, tj, fj;
    logic [RW-1:0] qj, qk, rob;
  } ment_t;

  ment_t         m [NENT];
  bit            m_ce;
  logic [31:0]   m_lhs, m_rhs, m_tj, m_fj;
  logic [4:0]    m_op;
  logic [RW-1:0] m_rob;

  function automatic bit m_full();
    for (int i = 0; i < NENT; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int iss;
    int fr;
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        m[i].busy = 1'b0; m[i].pj = 1'b0; m[i].pk = 1'b0;
      end
      m_ce = 1'b0; m_lhs = '0; m_rhs = '0; m_op = OP_NOP; m_rob = '0; m_tj = '0; m_fj = '0;
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < NENT; i++) m[i].busy = 1'b0;
        m_ce = 1'b0;
      end else begin
        iss = -1;
        fr  = -1;
        for (int i = 0; i < NENT; i++) begin
          if (iss < 0 && m[i].busy && !m[i].pj && !m[i].pk) iss = i;
          if (fr < 0 && !m[i].busy) fr = i;
        end
        m_ce = (iss >= 0);
        if (iss >= 0) begin
          m_lhs = m[iss].vj; m_rhs = m[iss].vk; m_op = m[iss].op;
          m_rob = m[iss].rob; m_tj = m[iss].tj; m_fj = m[iss].fj;
          m[iss].busy = 1'b0;
        end
        if (cdb_valid) begin
          for (int i = 0; i < NENT; i++) begin
            if (m[i].busy && m[i].pj && m[i].qj == cdb_rob) begin
              m[i].vj = cdb_value; m[i].pj = 1'b0;
            end
            if (m[i].busy && m[i].pk && m[i].qk == cdb_rob) begin
              m[i].vk = cdb_value; m[i].pk = 1'b0;
            end
          end
        end
        if (disp_valid && fr >= 0) begin
          m[fr].busy = 1'b1;
          m[fr].op = disp_op; m[fr].rob = disp_rob; m[fr].tj = disp_tj; m[fr].fj = disp_fj;
          m[fr].qj = disp_qj; m[fr].qk = disp_qk;
          m[fr].pj = disp_qj_valid; m[fr].vj = disp_vj;
          m[fr].pk = disp_qk_valid; m[fr].vk = disp_vk;
          if (disp_qj_valid && cdb_valid && cdb_rob == disp_qj) begin
            m[fr].pj = 1'b0; m[fr].vj = cdb_value;
          end
          if (disp_qk_valid && cdb_valid && cdb_rob == disp_qk) begin
            m[fr].pk = 1'b0; m[fr].vk = cdb_value;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_edge();

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.calc_enable", 32'(calc_enable), 32'(m_ce));
      chk("model.full", 32'(full), 32'(m_full()));
      chk("model.lhs", lhs, m_lhs);
      chk("model.rhs", rhs, m_rhs);
      chk("model.op", 32'(op), 32'(m_op));
      chk("model.rob_dep", 32'(rob_dep), 32'(m_rob));
      chk("model.true_jaddr", true_jaddr, m_tj);
      chk("model.false_jaddr", false_jaddr, m_fj);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0; clear = 1'b0; cdb_valid = 1'b0;
    disp_qj_valid = 1'b0; disp_qk_valid = 1'b0;
    disp_op = OP_NOP; disp_vj = '0; disp_vk = '0; disp_tj = '0; disp_fj = '0;
    disp_qj = '0; disp_qk = '0; disp_rob = '0; cdb_rob = '0; cdb_value = '0;
  endtask

  task automatic set_disp(input logic [4:0] o, input logic [31:0] vj, input logic [31:0] vk,
                          input bit pj, input logic [RW-1:0] qj, input bit pk,
                          input logic [RW-1:0] qk, input logic [RW-1:0] rb,
                          input logic [31:0] tj, input logic [31:0] fj);
    disp_valid = 1'b1; disp_op = o; disp_vj = vj; disp_vk = vk;
    disp_qj_valid = pj; disp_qj = qj; disp_qk_valid = pk; disp_qk = qk;
    disp_rob = rb; disp_tj = tj; disp_fj = fj;
  endtask

  task automatic chk_issue(string nm, logic [31:0] el, logic [31:0] er, logic [4:0] eo,
                           logic [RW-1:0] eb);
    chk({nm, ".calc_enable"}, 32'(calc_enable), 32'd1);
    chk({nm, ".lhs"}, lhs, el);
    chk({nm, ".rhs"}, rhs, er);
    chk({nm, ".op"}, 32'(op), 32'(eo));
    chk({nm, ".rob_dep"}, 32'(rob_dep), 32'(eb));
  endtask

  typedef struct {
    logic [4:0]    op;
    logic [31:0]   vj, vk, tj, fj;
    logic [RW-1:0] rob;
    logic [31:0]   exp_lhs, exp_rhs, exp_tj, exp_fj;
    logic [4:0]    exp_op;
    logic [RW-1:0] exp_rob;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3,
                32'd5, 32'd7, 32'd0, 32'd0, OP_ADD, 4'd3};
    vecs[1] = '{OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 32'd0, 4'd15,
                32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 32'd0, OP_XOR, 4'd15};
    vecs[2] = '{OP_BEQ, 32'd9, 32'd9, 32'h0000_1000, 32'h0000_0ABC, 4'd0,
                32'd9, 32'd9, 32'h0000_1000, 32'h0000_0ABC, OP_BEQ, 4'd0};
    vecs[3] = '{OP_BGEU, 32'h8000_0000, 32'd1, 32'hDEAD_BEE0, 32'h1234_5678, 4'd9,
                32'h8000_0000, 32'd1, 32'hDEAD_BEE0, 32'h1234_5678, OP_BGEU, 4'd9};

    idle();
    rst = 1'b1; rdy = 1'b1;
    step(); step();
    chk("reset.calc_enable", 32'(calc_enable), 32'd0);
    chk("reset.full", 32'(full), 32'd0);
    chk("reset.op", 32'(op), 32'(5'b11111));
    chk("reset.lhs", lhs, 32'd0);
    chk("reset.rhs", rhs, 32'd0);
    chk("reset.rob_dep", 32'(rob_dep), 32'd0);
    chk("reset.true_jaddr", true_jaddr, 32'd0);
    chk("reset.false_jaddr", false_jaddr, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Both operands ready at dispatch: calc_enable two edges later, for one cycle.
    for (int v = 0; v < 4; v++) begin
      set_disp(vecs[v].op, vecs[v].vj, vecs[v].vk, 1'b0, '0, 1'b0, '0, vecs[v].rob,
               vecs[v].tj, vecs[v].fj);
      step(); idle();
      chk($sformatf("vec%0d.early", v), 32'(calc_enable), 32'd0);
      step();
      chk_issue($sformatf("vec%0d", v), vecs[v].exp_lhs, vecs[v].exp_rhs, vecs[v].exp_op,
                vecs[v].exp_rob);
      chk($sformatf("vec%0d.true_jaddr", v), true_jaddr, vecs[v].exp_tj);
      chk($sformatf("vec%0d.false_jaddr", v), false_jaddr, vecs[v].exp_fj);
      step();
      chk($sformatf("vec%0d.single", v), 32'(calc_enable), 32'd0);
    end

    // Wakeup: cdb in cycle 3 -> calc_enable in cycle 5.
    set_disp(OP_SUB, 32'hDEAD, 32'd9, 1'b1, 4'd4, 1'b0, '0, 4'd6, '0, '0);
    step(); idle();
    chk("wake.c1", 32'(calc_enable), 32'd0);
    step();
    chk("wake.c2", 32'(calc_enable), 32'd0);
    step();
    cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_value = 32'd100;
    chk("wake.c3", 32'(calc_enable), 32'd0);
    step(); idle();
    chk("wake.c4", 32'(calc_enable), 32'd0);
    step();
    chk_issue("wake.c5", 32'd100, 32'd9, OP_SUB, 4'd6);
    step();
    chk("wake.c6", 32'(calc_enable), 32'd0);

    // Bypass: cdb in the dispatch cycle behaves as if ready at dispatch.
    set_disp(OP_SUB, 32'd0, 32'd9, 1'b1, 4'd4, 1'b0, '0, 4'd7, '0, '0);
    cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_value = 32'd200;
    step(); idle();
    chk("bypass.c1", 32'(calc_enable), 32'd0);
    step();
    chk_issue("bypass.c2", 32'd200, 32'd9, OP_SUB, 4'd7);
    step();
    chk("bypass.c3", 32'(calc_enable), 32'd0);

    // Fill all eight, drop a ninth, release together, expect index order.
    for (int i = 0; i < NENT; i++) begin
      chk($sformatf("fill.notfull%0d", i), 32'(full), 32'd0);
      set_disp(OP_ADD, 32'd0, 32'(i * 10), 1'b1, 4'd5, 1'b0, '0, RW'(i), '0, '0);
      step();
    end
    idle();
    chk("fill.full", 32'(full), 32'd1);
    set_disp(OP_AND, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, '0, 4'd15, '0, '0);
    step(); idle();
    chk("fill.full_after_drop", 32'(full), 32'd1);
    chk("fill.no_issue", 32'(calc_enable), 32'd0);
    cdb_valid = 1'b1; cdb_rob = 4'd5; cdb_value = 32'd77;
    step(); idle();
    chk("fill.woken", 32'(calc_enable), 32'd0);
    for (int i = 0; i < NENT; i++) begin
      step();
      chk_issue($sformatf("fill.issue%0d", i), 32'd77, 32'(i * 10), OP_ADD, RW'(i));
      if (i == 0) chk("fill.full_freed", 32'(full), 32'd0);
    end
    step();
    chk("fill.drained", 32'(calc_enable), 32'd0);

    // Pause with calc_enable high: everything holds, nothing lost or duplicated.
    set_disp(OP_OR, 32'd11, 32'd12, 1'b0, '0, 1'b0, '0, 4'd1, '0, '0);
    step();
    set_disp(OP_OR, 32'd21, 32'd22, 1'b0, '0, 1'b0, '0, 4'd2, '0, '0);
    step(); idle();
    chk_issue("pause.pre", 32'd11, 32'd12, OP_OR, 4'd1);
    rdy = 1'b0;
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0, 4'd7, '0, '0);
    cdb_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_issue($sformatf("pause.hold%0d", k), 32'd11, 32'd12, OP_OR, 4'd1);
    end
    rdy = 1'b1; idle();
    step();
    chk_issue("pause.next", 32'd21, 32'd22, OP_OR, 4'd2);
    step();
    chk("pause.done", 32'(calc_enable), 32'd0);
    chk("pause.empty", 32'(full), 32'd0);

    // Flush with five waiting entries while an issue is being presented.
    for (int i = 0; i < 4; i++) begin
      set_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, '0, RW'(11 + i), '0, '0);
      step();
    end
    set_disp(OP_SLT, 32'h55, 32'h66, 1'b0, '0, 1'b0, '0, 4'd10, '0, '0);
    step();
    set_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, '0, 4'd15, '0, '0);
    step(); idle();
    chk_issue("clear.pre", 32'h55, 32'h66, OP_SLT, 4'd10);
    clear = 1'b1; cdb_valid = 1'b1; cdb_rob = 4'd3; cdb_value = 32'd1;
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0, 4'd9, '0, '0);
    step(); idle();
    chk("clear.calc_enable", 32'(calc_enable), 32'd0);
    chk("clear.full", 32'(full), 32'd0);
    cdb_valid = 1'b1; cdb_rob = 4'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("clear.quiet%0d", k), 32'(calc_enable), 32'd0);
    end
    idle();

    // Reset mid-operation, with rdy_in low.
    set_disp(OP_BNE, 32'h1234, 32'h99, 1'b0, '0, 1'b0, '0, 4'd5, 32'h40, 32'h44);
    step();
    set_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, '0, 4'd6, '0, '0);
    step(); idle();
    chk_issue("rst.pre", 32'h1234, 32'h99, OP_BNE, 4'd5);
    rst = 1'b1; rdy = 1'b0;
    step();
    chk("rst.calc_enable", 32'(calc_enable), 32'd0);
    chk("rst.lhs", lhs, 32'd0);
    chk("rst.rhs", rhs, 32'd0);
    chk("rst.op", 32'(op), 32'(5'b11111));
    chk("rst.rob_dep", 32'(rob_dep), 32'd0);
    chk("rst.true_jaddr", true_jaddr, 32'd0);
    chk("rst.false_jaddr", false_jaddr, 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    rst = 1'b0; rdy = 1'b1;
    cdb_valid = 1'b1; cdb_rob = 4'd2;
    step(); idle();
    step();
    chk("rst.gone0", 32'(calc_enable), 32'd0);
    step();
    chk("rst.gone1", 32'(calc_enable), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 499) == 0);
      rdy           = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 39) == 0);
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_op       = 5'($urandom_range(0, 15));
      disp_vj       = $urandom;
      disp_vk       = $urandom;
      disp_qj_valid = ($urandom_range(0, 1) == 1);
      disp_qk_valid = ($urandom_range(0, 1) == 1);
      disp_qj       = RW'($urandom_range(0, 7));
      disp_qk       = RW'($urandom_range(0, 7));
      disp_rob      = RW'($urandom);
      disp_tj       = $urandom;
      disp_fj       = $urandom;
      cdb_valid     = ($urandom_range(0, 9) < 4);
      cdb_rob       = RW'($urandom_range(0, 7));
      cdb_value     = $urandom;
      step();
    end
    idle(); rst = 1'b0; rdy = 1'b1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
